// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int          DIGIT_W           = 4;
    localparam logic [3:0]  BCD_MAX_PER_DIGIT = 4'd9;

    // 10^n, used as the first operand value that no longer fits in n digits.
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Add-3 correction applied to one BCD digit before each shift of the double-dabble loop.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
// Build option: define BIN2BCD_SAT_EN to saturate bcd to all nines on overflow.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [DIGIT_W*DIGITS-1:0]   bcd,
    output logic                        overflow
);

    localparam int          BCD_W = DIGIT_W * DIGITS;
    localparam int          CNT_W = $clog2(BIN_W + 1);
    localparam logic [31:0] LIMIT = pow10(DIGITS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_sh_q, bin_sh_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic [BCD_W-1:0]   adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
            .dout (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_sh_d   = bin_sh_q;
        scratch_d  = scratch_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sh_d   = bin;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    ovf_pend_d = (32'(bin) >= LIMIT);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Top bit of the corrected scratch falls off: result is bin mod 10^DIGITS.
                scratch_d = {adj[BCD_W-2:0], bin_sh_q[BIN_W-1]};
                bin_sh_d  = {bin_sh_q[BIN_W-2:0], 1'b0};
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef BIN2BCD_SAT_EN
                bcd_d = ovf_pend_q ? {DIGITS{BCD_MAX_PER_DIGIT}} : scratch_q;
`else
                bcd_d = scratch_q;
`endif
                overflow_d = ovf_pend_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
        end
        // Datapath registers are always loaded before use, so they skip reset.
        bin_sh_q   <= bin_sh_d;
        scratch_q  <= scratch_d;
        ovf_pend_q <= ovf_pend_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq at default parameters.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts a conversion of v and watches 30 cycles after acceptance.
    // Optionally changes bin to alt at cycle chg_k and pulses start at cycles pa/pb.
    task automatic conv_and_check(input string tag, input logic [13:0] v, input logic [13:0] alt,
                                  input int chg_k, input int pa, input int pb,
                                  input logic [15:0] exp_bcd, input logic exp_ovf);
        int lat;
        int busy_n;
        int done_n;
        lat    = -1;
        busy_n = 0;
        done_n = 0;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 30; k++) begin
            start = (k == pa) || (k == pb);
            if (k == chg_k) bin = alt;
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) lat = k;
            end
        end
        start = 1'b0;
        check_val({tag, "_latency"}, lat, 15);
        check_val({tag, "_busy_cycles"}, busy_n, 14);
        check_val({tag, "_done_pulses"}, done_n, 1);
        check_val({tag, "_bcd"}, {16'd0, bcd}, {16'd0, exp_bcd});
        check_val({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    initial begin
        int d1;
        int d2;
        int done_n;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_bcd", {16'd0, bcd}, 32'd0);
        check_val("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        conv_and_check("zero", 14'd0, 14'd0, 0, 0, 0, 16'h0000, 1'b0);
        conv_and_check("v1234", 14'd1234, 14'd5678, 6, 0, 0, 16'h1234, 1'b0);
        conv_and_check("v2468_ign", 14'd2468, 14'd0, 0, 3, 8, 16'h2468, 1'b0);

        // Start held high: results every BIN_W+2 cycles.
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        bin   = 14'd9999;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
        end
        start = 1'b0;
        check_val("b2b_latency", d1, 15);
        check_val("b2b_gap", d2 - d1, 16);
        check_val("b2b_bcd", {16'd0, bcd}, 32'h9999);
        check_val("b2b_overflow", {31'd0, overflow}, 32'd0);
        repeat (20) @(posedge clk);

`ifdef BIN2BCD_SAT_EN
        conv_and_check("v12345", 14'd12345, 14'd0, 0, 0, 0, 16'h9999, 1'b1);
`else
        conv_and_check("v12345", 14'd12345, 14'd0, 0, 0, 0, 16'h2345, 1'b1);
`endif

        // Abort a conversion of 4321 partway through the shift phase.
        @(negedge clk);
        bin   = 14'd4321;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_bcd", {16'd0, bcd}, 32'd0);
        check_val("abort_overflow", {31'd0, overflow}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        done_n = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (done) done_n++;
        end
        check_val("abort_no_done", done_n, 0);

        conv_and_check("v4321", 14'd4321, 14'd0, 0, 0, 0, 16'h4321, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
